alu_mux_rr_arbiter: RTL and testbench

Round-robin arbiter that owns the 3-bit select of the ALU's 8-input result mux and shares it among eight requesters. Each requester asks for the mux with a request line. It holds ownership until it releases, drops its request, or hits a hold-time limit. The block drives the mux select and a one-hot grant, so exactly one source steers the mux at a time. It sits between the execute-stage control logic and the 8:1 result mux in the ALU.

---
 rtl/alu_arb_pkg.sv | 12 +
 rtl/rr_pick8.sv | 29 ++
 rtl/alu_mux_rr_arbiter.sv | 97 +++++++++
 tb/tb_alu_mux_rr_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared sizing constants and FSM state type for the ALU result-mux arbiter.
package alu_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage : alu_arb_pkg

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 8.
module rr_pick8
  import alu_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [SEL_W-1:0]   pick_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [SEL_W-1:0]     rot_idx;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_i;
    req_rot = req_dbl[NUM_REQ-1:0];
    rot_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_rot[NUM_REQ-1-i]) begin
        rot_idx = SEL_W'(NUM_REQ-1-i);
      end
    end
    pick_o = rot_idx + ptr_i;
    any_o  = |req_i;
  end

endmodule : rr_pick8

// File: rtl/alu_mux_rr_arbiter.sv
// Round-robin owner of the ALU 8:1 result-mux select, with hold-time limit.
module alu_mux_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] release_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               busy_o,
  output logic               timeout_o
);

  arb_state_e         state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   owner_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic               busy_q;
  logic               timeout_q;

  logic [SEL_W-1:0]   pick;
  logic               any_req;
  logic [NUM_REQ-1:0] grant_d;
  logic               exit_normal;
  logic               exit_forced;

  rr_pick8 u_pick (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  // Next one-hot grant and BUSY exit conditions; a release always beats a timeout.
  always_comb begin
    grant_d     = NUM_REQ'(1) << pick;
    exit_normal = release_i[owner_q] | ~req_i[owner_q];
    exit_forced = ~exit_normal && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  end

  // Arbitration FSM with registered grant, select, busy and timeout outputs.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (any_req) begin
            owner_q    <= pick;
            sel_q      <= pick;
            grant_q    <= grant_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= BUSY;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        BUSY: begin
          if (exit_normal || exit_forced) begin
            grant_q    <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= owner_q + 1'b1;
            hold_cnt_q <= '0;
            timeout_q  <= exit_forced;
            state_q    <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            timeout_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule : alu_mux_rr_arbiter

// File: tb/tb_alu_mux_rr_arbiter.sv
// Scoreboard bench for alu_mux_rr_arbiter against a cycle-level ownership model.
module tb_alu_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] rel;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  exp_t q[$];
  int   vectors;
  int   miscompares;

  // Model state: who owns, how many cycles it has been granted, next priority index.
  bit   m_busy;
  int   m_owner;
  int   m_held;
  int   m_ptr;
  int   m_sel;

  alu_mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .req_i     (req),
    .release_i (rel),
    .grant_o   (grant),
    .sel_o     (sel),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs and push the outputs expected after the next edge.
  task automatic apply(input logic [7:0] r, input logic [7:0] rl, input bit rs);
    exp_t e;
    bit   found;
    @(negedge clock);
    req     = r;
    rel     = rl;
    reset_n = ~rs;
    e = '0;
    if (rs) begin
      m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_sel = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (!found && r[idx]) begin
          found   = 1;
          m_owner = idx;
        end
      end
      if (found) begin
        m_busy = 1;
        m_held = 1;
        m_sel  = m_owner;
      end
    end else begin
      if (rl[m_owner] || !r[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 8;
      end else if (m_held == MAX_HOLD) begin
        m_busy    = 0;
        m_ptr     = (m_owner + 1) % 8;
        e.timeout = 1'b1;
      end else begin
        m_held++;
      end
    end
    e.sel  = 3'(m_sel);
    e.busy = m_busy;
    if (m_busy) e.grant = 8'(1 << m_owner);
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs shortly after every edge that has a prediction.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{grant, sel, busy, timeout};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got grant=%h sel=%0d busy=%b timeout=%b, want grant=%h sel=%0d busy=%b timeout=%b",
                   $time, a.grant, a.sel, a.busy, a.timeout, e.grant, e.sel, e.busy, e.timeout);
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] rl;
    vectors = 0; miscompares = 0;
    m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_sel = 0;
    req = '0; rel = '0; reset_n = 1'b0;

    // Reset, then idle.
    repeat (2) apply(8'h00, 8'h00, 1);
    repeat (5) apply(8'h00, 8'h00, 0);

    // Single requester 4, released on its third granted cycle.
    repeat (3) apply(8'h10, 8'h00, 0);
    apply(8'h10, 8'h10, 0);
    repeat (2) apply(8'h00, 8'h00, 0);

    // Fairness: everyone requests, every owner releases immediately.
    repeat (36) apply(8'hFF, 8'hFF, 0);
    apply(8'h00, 8'h00, 0);

    // Timeout with no release, then re-grant after one idle cycle.
    repeat (22) apply(8'h04, 8'h00, 0);
    apply(8'h00, 8'h00, 0);

    // Release arriving on the would-be timeout cycle.
    for (int c = 0; c < 12; c++) begin
      rl = (m_busy && m_held == MAX_HOLD) ? 8'h08 : 8'h00;
      apply(8'h08, rl, 0);
    end
    apply(8'h00, 8'h00, 0);

    // Non-owner release ignored while requester 5 owns.
    repeat (5) apply(8'h20, 8'h08, 0);
    apply(8'h00, 8'h00, 0);

    // Reset mid-BUSY, then requester 0 wins from ptr 0.
    repeat (3) apply(8'h40, 8'h00, 0);
    apply(8'h40, 8'h00, 1);
    repeat (3) apply(8'h41, 8'h00, 0);

    // Random traffic, owners mostly keep requesting so timeouts also occur.
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom);
      if (m_busy && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      rl = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      apply(r, rl, $urandom_range(0, 99) == 0);
    end

    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu_mux_rr_arbiter
